// File: rtl/program_loader.sv
// program_loader: receives a valid/ready byte stream of the form
// header N, then N big-endian 16-bit words, and writes them into a
// 32-entry instruction memory. Addresses N..31 are filled with NOP_WORD.
// After all 32 writes, load_done is raised and held. A header outside
// 1..32 raises load_err instead. Both levels clear on start or RST.
module program_loader #(
  parameter int                 ADDR_W   = 5,
  parameter int                 INSTR_W  = 16,
  parameter int                 BYTE_W   = 8,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  input  logic               start,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               load_done,
  output logic               load_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_HDR, S_HI, S_LO, S_FILL, S_DONE, S_ERR
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W:0]      r_n, w_n_nxt;
  logic [ADDR_W:0]      r_wr_ptr, w_ptr_nxt;
  logic [BYTE_W-1:0]    r_hi, w_hi_nxt;
  logic                 r_byte_ready;
  logic                 r_mem_we, w_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr, w_mem_addr;
  logic [INSTR_W-1:0]   r_mem_wdata, w_mem_wdata;
  logic                 r_load_done, r_load_err;
  logic                 w_xfer;
  logic                 w_hdr_ok;
  logic [ADDR_W:0]      w_ptr_inc;

  assign w_xfer    = byte_valid & r_byte_ready;
  assign w_hdr_ok  = (int'(byte_in) >= 1) && (int'(byte_in) <= DEPTH);
  assign w_ptr_inc = r_wr_ptr + PTR_ONE;

  // State register together with word count, write pointer and held hi byte
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_HDR;
      r_n      <= '0;
      r_wr_ptr <= '0;
      r_hi     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_n      <= w_n_nxt;
      r_wr_ptr <= w_ptr_nxt;
      r_hi     <= w_hi_nxt;
    end
  end

  // Next-state decode: frame parsing, fill sequencing and reload handling
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR:  if (w_xfer) w_state_nxt = w_hdr_ok ? S_HI : S_ERR;
      S_HI:   if (w_xfer) w_state_nxt = S_LO;
      S_LO: begin
        if (w_xfer) begin
          if (w_ptr_inc == r_n) w_state_nxt = (r_n == PTR_FULL) ? S_DONE : S_FILL;
          else                  w_state_nxt = S_HI;
        end
      end
      S_FILL: if (r_wr_ptr == PTR_LAST) w_state_nxt = S_DONE;
      S_DONE: if (start) w_state_nxt = S_HDR;
      S_ERR:  if (start) w_state_nxt = S_HDR;
      default: w_state_nxt = S_HDR;
    endcase
  end

  // Output/datapath decode: next write strobe, address, data and counters
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_n_nxt     = r_n;
    w_ptr_nxt   = r_wr_ptr;
    w_hi_nxt    = r_hi;
    case (r_state)
      S_HDR: begin
        if (w_xfer && w_hdr_ok) begin
          w_n_nxt   = byte_in[ADDR_W:0];
          w_ptr_nxt = '0;
        end
      end
      S_HI: begin
        if (w_xfer) w_hi_nxt = byte_in;
      end
      S_LO: begin
        if (w_xfer) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_wr_ptr[ADDR_W-1:0];
          w_mem_wdata = {r_hi, byte_in};
          w_ptr_nxt   = w_ptr_inc;
        end
      end
      S_FILL: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_wr_ptr[ADDR_W-1:0];
        w_mem_wdata = NOP_WORD;
        w_ptr_nxt   = w_ptr_inc;
      end
      default: ;
    endcase
  end

  // Registered outputs; load_done trails the final write pulse by one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_byte_ready <= (w_state_nxt == S_HDR) || (w_state_nxt == S_HI) ||
                      (w_state_nxt == S_LO);
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_load_done  <= (r_state == S_DONE) && (w_state_nxt == S_DONE);
      r_load_err   <= (w_state_nxt == S_ERR);
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

endmodule
